// File: rtl/rv32i_pkg.sv
// Shared fetch-path types and constants: entry layout, queue depth, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

  // Canonical NOP (addi x0, x0, 0), returned for faulting fetches
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Depth of both the PC queue and the output FIFO; also the fetch credit limit
  localparam int IF_DEPTH = 2;

  // One fetched instruction as presented to decode
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } if_state_e;

  // Word-aligned memory address for a fetch PC
  function automatic logic [31:0] word_addr(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO with push, pop and synchronous clear; head is combinational from storage.
// Latency: a push is visible at the head the cycle after it is written.
// Backpressure: push is ignored when full unless a pop frees a slot the same cycle; clear wins over both.
module fetch_fifo
  import rv32i_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_dat_i,
  input  logic         pop_i,
  output logic [W-1:0] head_dat_o,
  output logic [1:0]   cnt_o
);

  // Pointers are a single bit because the FIFO holds exactly IF_DEPTH = 2 entries
  logic [W-1:0] mem_q [IF_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop_i & (cnt_q != 2'd0);
  assign do_push = push_i & ((cnt_q != 2'(IF_DEPTH)) | do_pop);

  assign head_dat_o = mem_q[rd_ptr_q];
  assign cnt_o      = cnt_q;

  // Storage: written only on an accepted push, never cleared
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointer and occupancy tracking; reset and clear both empty the FIFO
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word reads for PCs and pairs each response with its PC for decode.
// Latency: PC accepted combinationally on grant; response in cycle N is offered to decode in cycle N+1.
// Backpressure: at most 2 fetches in flight or buffered; ImemReq/PCReady drop until decode drains.
// Optional build macro IFETCH_MISALIGN_CHK_EN turns misaligned PCs into faulting NOP entries.
module instr_fetch
  import rv32i_pkg::*;
(
  input  logic        Clk,
  input  logic        Rst,
  input  logic [31:0] PC,
  input  logic        PCValid,
  output logic        PCReady,
  input  logic        Flush,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrFault,
  input  logic        DecReady
);

  if_state_e    state_q;
  logic [1:0]   outstanding_q;
  logic [1:0]   outstanding_d;
  logic [1:0]   discard_cnt_q;

  logic [1:0]   ofifo_cnt;
  fetch_entry_t ofifo_head;
  fetch_entry_t ofifo_push_dat;
  logic         ofifo_push;
  logic         ofifo_pop;

  logic [1:0]   pcq_cnt;
  logic [31:0]  pcq_head;

  logic         credit;
  logic         pc_aligned;
  logic         imem_req;
  logic         grant;
  logic         rsp_vld;
  logic         rsp_keep;
  logic         mis_acc;
  logic         instr_vld;

  // Credit covers both requests in flight and entries waiting for decode,
  // so a response can always be written into the output FIFO.
  assign credit = ({1'b0, outstanding_q} + {1'b0, ofifo_cnt}) < 3'(IF_DEPTH);

`ifdef IFETCH_MISALIGN_CHK_EN
  assign pc_aligned = (PC[1:0] == 2'b00);
  // A faulting PC bypasses memory; waiting for Outstanding = 0 keeps it in program order
  assign mis_acc    = PCValid & ~pc_aligned & (ofifo_cnt < 2'(IF_DEPTH))
                    & (outstanding_q == 2'd0) & ~Flush & ~Rst;
`else
  assign pc_aligned = 1'b1;
  assign mis_acc    = 1'b0;
`endif

  assign imem_req = PCValid & credit & pc_aligned & ~Flush & ~Rst;
  assign grant    = imem_req & ImemGnt;

  // A response with nothing outstanding belongs to a pre-reset request and is ignored
  assign rsp_vld  = ImemRvalid & (outstanding_q != 2'd0);
  // Responses are kept only in RUN; in DRAIN they belong to flushed requests
  assign rsp_keep = rsp_vld & (state_q == ST_RUN) & ~Flush & (pcq_cnt != 2'd0);

  assign instr_vld = (ofifo_cnt != 2'd0);
  assign ofifo_pop = instr_vld & DecReady & ~Flush;
  assign ofifo_push = rsp_keep | mis_acc;

  // Output FIFO write data: memory response paired with its PC, or a faulting NOP
  always_comb begin
    ofifo_push_dat       = '0;
    ofifo_push_dat.pc    = pcq_head;
    ofifo_push_dat.instr = ImemRdata;
    ofifo_push_dat.fault = 1'b0;
    if (mis_acc) begin
      ofifo_push_dat.pc    = PC;
      ofifo_push_dat.instr = NOP_INSTR;
      ofifo_push_dat.fault = 1'b1;
    end
  end

  // Requests in flight: up on grant, down on any response (kept or dropped)
  always_comb begin
    outstanding_d = outstanding_q;
    if (grant && !rsp_vld) begin
      outstanding_d = outstanding_q + 2'd1;
    end else if (!grant && rsp_vld) begin
      outstanding_d = outstanding_q - 2'd1;
    end
  end

  // RUN/DRAIN control: a flush arms the discard counter with whatever is still in flight
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= ST_RUN;
      discard_cnt_q <= 2'd0;
      outstanding_q <= 2'd0;
    end else begin
      outstanding_q <= outstanding_d;
      if (Flush) begin
        // No grant can occur during a flush, so outstanding_d is the in-flight
        // count minus this cycle's response: exactly the responses left to drop.
        discard_cnt_q <= outstanding_d;
        state_q       <= (outstanding_d != 2'd0) ? ST_DRAIN : ST_RUN;
      end else begin
        case (state_q)
          ST_RUN: begin
            discard_cnt_q <= 2'd0;
          end
          ST_DRAIN: begin
            if (rsp_vld) begin
              discard_cnt_q <= discard_cnt_q - 2'd1;
              if (discard_cnt_q == 2'd1) begin
                state_q <= ST_RUN;
              end
            end
          end
        endcase
      end
    end
  end

  // PCs of granted requests, in the order their responses will return
  fetch_fifo #(
    .W (32)
  ) u_pc_queue (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .clr_i      (Flush),
    .push_i     (grant),
    .push_dat_i (PC),
    .pop_i      (rsp_keep),
    .head_dat_o (pcq_head),
    .cnt_o      (pcq_cnt)
  );

  // Fetched instructions waiting for decode
  fetch_fifo #(
    .W ($bits(fetch_entry_t))
  ) u_out_fifo (
    .clk_i      (Clk),
    .rst_i      (Rst),
    .clr_i      (Flush),
    .push_i     (ofifo_push),
    .push_dat_i (ofifo_push_dat),
    .pop_i      (ofifo_pop),
    .head_dat_o (ofifo_head),
    .cnt_o      (ofifo_cnt)
  );

  assign ImemReq    = imem_req;
  assign ImemAddr   = word_addr(PC);
  assign PCReady    = grant | mis_acc;

  // Decode-facing outputs are forced quiet while reset is held
  assign InstrValid = instr_vld & ~Rst;
  assign Instr      = Rst ? 32'h0 : ofifo_head.instr;
  assign InstrPC    = Rst ? 32'h0 : ofifo_head.pc;

`ifdef IFETCH_MISALIGN_CHK_EN
  assign InstrFault = instr_vld & ~Rst & ofifo_head.fault;
`else
  // Fault bit is always written as 0 in this build
  logic unused_fault;
  assign unused_fault = ofifo_head.fault;
  assign InstrFault   = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory model with fixed latency plus an in-order scoreboard.
// Latency: expected entries are stamped with the cycle decode should first see them.
// Backpressure: DecReady is driven per test to exercise stall, flush and reset paths.
module tb_instr_fetch;

  logic        Clk;
  logic        Rst;
  logic [31:0] PC;
  logic        PCValid;
  logic        PCReady;
  logic        Flush;
  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemGnt;
  logic        ImemRvalid;
  logic [31:0] ImemRdata;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [31:0] InstrPC;
  logic        InstrFault;
  logic        DecReady;

  instr_fetch dut (
    .Clk        (Clk),
    .Rst        (Rst),
    .PC         (PC),
    .PCValid    (PCValid),
    .PCReady    (PCReady),
    .Flush      (Flush),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemGnt    (ImemGnt),
    .ImemRvalid (ImemRvalid),
    .ImemRdata  (ImemRdata),
    .InstrValid (InstrValid),
    .Instr      (Instr),
    .InstrPC    (InstrPC),
    .InstrFault (InstrFault),
    .DecReady   (DecReady)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        fault;
    int          due;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    int          due;
    bit          keep;
  } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          mem_lat = 2;
  bit          chk_lat = 0;
  int          seq     = 0;
  bit          rsp_keep = 0;
  logic [31:0] rsp_pc   = 32'h0;

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory: grants seen mid-cycle, response driven mem_lat cycles later.
  // Kept responses are pushed to the scoreboard; flush/reset retire pending ones.
  initial begin : mem_model
    pend_t f;
    ImemRvalid = 1'b0;
    ImemRdata  = 32'h0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        pend.delete();
      end else begin
        if (ImemRvalid && rsp_keep && !Flush)
          sb.push_back('{pc: rsp_pc, instr: ImemRdata, fault: 1'b0, due: cyc + 1});
        if (Flush)
          foreach (pend[i]) pend[i].keep = 1'b0;
        if (ImemReq && ImemGnt) begin
          pend.push_back('{pc: PC, data: 32'hDA7A_0000 + 32'(seq), due: cyc + mem_lat, keep: 1'b1});
          seq++;
        end
      end
      @(posedge Clk);
      #1;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        f = pend.pop_front();
        ImemRvalid = 1'b1;
        ImemRdata  = f.data;
        rsp_pc     = f.pc;
        rsp_keep   = f.keep;
      end else begin
        ImemRvalid = 1'b0;
        rsp_keep   = 1'b0;
      end
    end
  end

  // Decode side: every consumed instruction must match the scoreboard head
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge Clk);
      if (Rst || Flush) begin
        sb.delete();
      end else if (InstrValid && DecReady) begin
        if (sb.size() == 0) begin
          check("spurious_instr", 32'(InstrValid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("instr_pc", InstrPC, e.pc);
          check("instr_dat", Instr, e.instr);
          check("instr_fault", 32'(InstrFault), 32'(e.fault));
          if (chk_lat) check("instr_lat", 32'(cyc), 32'(e.due));
        end
      end
    end
  end

  // Present n consecutive PCs from base, holding each until accepted
  task automatic issue(input logic [31:0] base, input int n, input int budget);
    int sent = 0;
    int k    = 0;
    bit acc;
    PC      = base;
    PCValid = 1'b1;
    while (sent < n && k < budget) begin
      @(negedge Clk);
      k++;
      acc = PCReady;
      if (acc) sent++;
      @(posedge Clk);
      #1;
      if (acc) begin
        if (sent < n) PC = PC + 32'd4;
        else PCValid = 1'b0;
      end
    end
    if (sent < n) check("issue_timeout", 32'(sent), 32'(n));
    PCValid = 1'b0;
  endtask

  // Wait until the memory model has returned every pending response
  task automatic wait_rsp_done(input int budget);
    bit done = 0;
    for (int k = 0; k < budget && !done; k++) begin
      @(negedge Clk);
      done = (pend.size() == 0) && !ImemRvalid;
    end
    if (!done) check("rsp_timeout", 32'(pend.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  // Wait until nothing is pending in memory or awaiting decode
  task automatic wait_idle(input int budget);
    bit idle = 0;
    for (int k = 0; k < budget && !idle; k++) begin
      @(negedge Clk);
      idle = (pend.size() == 0) && (sb.size() == 0) && !ImemRvalid && !InstrValid;
    end
    if (!idle) check("idle_timeout", 32'(pend.size() + sb.size()), 32'd0);
    @(posedge Clk);
    #1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    Rst = 1'b1; PC = 32'h40; PCValid = 1'b1; Flush = 1'b0; ImemGnt = 1'b1; DecReady = 1'b1;

    // Reset: outputs quiet even with a valid PC presented
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_imemreq", 32'(ImemReq), 32'd0);
    check("rst_pcready", 32'(PCReady), 32'd0);
    check("rst_instrvalid", 32'(InstrValid), 32'd0);
    check("rst_fault", 32'(InstrFault), 32'd0);
    check("rst_instr", Instr, 32'h0);
    check("rst_instrpc", InstrPC, 32'h0);
    @(posedge Clk);
    #1;
    Rst = 1'b0; PCValid = 1'b0;

    // Stream: PCs 0,4,8, latency 2, decode always ready
    mem_lat = 2; chk_lat = 1'b1;
    issue(32'h0, 3, 60);
    wait_idle(60);
    chk_lat = 1'b0;

    // Backpressure: two entries held, fetch must stall until one is consumed
    DecReady = 1'b0;
    issue(32'h20, 2, 60);
    wait_rsp_done(60);
    PCValid = 1'b1; PC = 32'h28;
    @(negedge Clk);
    check("bp_imemreq", 32'(ImemReq), 32'd0);
    check("bp_pcready", 32'(PCReady), 32'd0);
    check("bp_head_pc", InstrPC, 32'h20);
    @(posedge Clk); #1;
    @(negedge Clk);
    check("bp_head_stable", InstrPC, 32'h20);
    check("bp_valid", 32'(InstrValid), 32'd1);
    @(posedge Clk); #1;
    DecReady = 1'b1;
    @(negedge Clk);
    check("bp_imemreq_pop", 32'(ImemReq), 32'd0);
    @(posedge Clk); #1;
    DecReady = 1'b0;
    @(negedge Clk);
    check("bp_imemreq_back", 32'(ImemReq), 32'd1);
    @(posedge Clk); #1;
    PCValid = 1'b0; DecReady = 1'b1;
    wait_idle(60);

    // Flush with two in flight: both dropped, the redirect target is kept
    mem_lat = 4;
    issue(32'h40, 2, 60);
    Flush = 1'b1; PCValid = 1'b1; PC = 32'h100;
    @(negedge Clk);
    check("flush_imemreq", 32'(ImemReq), 32'd0);
    check("flush_pcready", 32'(PCReady), 32'd0);
    @(posedge Clk); #1;
    Flush = 1'b0;
    issue(32'h100, 1, 60);
    wait_idle(60);

    // Flush in the same cycle as a decode pop: nothing survives
    mem_lat = 1; DecReady = 1'b0;
    issue(32'h60, 2, 60);
    wait_rsp_done(60);
    Flush = 1'b1; DecReady = 1'b1;
    @(negedge Clk);
    check("fpop_valid_before", 32'(InstrValid), 32'd1);
    @(posedge Clk); #1;
    Flush = 1'b0;
    @(negedge Clk);
    check("fpop_valid_after", 32'(InstrValid), 32'd0);
    @(posedge Clk); #1;
    wait_idle(60);

    // Reset with one outstanding request and one queued entry
    mem_lat = 4; DecReady = 1'b0;
    issue(32'h80, 1, 60);
    wait_rsp_done(60);
    issue(32'h84, 1, 60);
    Rst = 1'b1; PCValid = 1'b1; PC = 32'h0;
    @(posedge Clk); #1;
    @(negedge Clk);
    check("mrst_valid", 32'(InstrValid), 32'd0);
    check("mrst_imemreq", 32'(ImemReq), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0; PCValid = 1'b0;
    @(negedge Clk);
    check("mrst_valid_post", 32'(InstrValid), 32'd0);
    @(posedge Clk); #1;
    DecReady = 1'b1; mem_lat = 2;
    issue(32'h0, 1, 60);
    wait_idle(60);

`ifdef IFETCH_MISALIGN_CHK_EN
    // Misaligned PC: no memory request, faulting NOP appears next cycle
    chk_lat = 1'b1;
    PCValid = 1'b1; PC = 32'h6;
    @(negedge Clk);
    check("mis_imemreq", 32'(ImemReq), 32'd0);
    check("mis_pcready", 32'(PCReady), 32'd1);
    if (PCReady) sb.push_back('{pc: 32'h6, instr: 32'h00000013, fault: 1'b1, due: cyc + 1});
    @(posedge Clk); #1;
    PCValid = 1'b0;
    @(negedge Clk);
    check("mis_valid", 32'(InstrValid), 32'd1);
    check("mis_fault", 32'(InstrFault), 32'd1);
    check("mis_instr", Instr, 32'h00000013);
    check("mis_pc", InstrPC, 32'h6);
    @(posedge Clk); #1;
    wait_idle(60);
    chk_lat = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have a single clock and a single reset: `Clk` (1 bit, input, rising-edge clock) and `Rst` (1 bit, input). `Rst` is synchronous and active-high.
REQ-002 `PC` input, 32 bits: fetch address presented by the PC stage.
REQ-003 `PCValid` input, 1 bit: `PC` holds a valid fetch address.
REQ-004 `PCReady` output, 1 bit: the fetch address is accepted this cycle; the PC stage holds `PC` until it sees this.
REQ-005 `Flush` input, 1 bit: redirect. Discards all fetched and in-flight instructions.
REQ-006 `ImemReq` output, 1 bit: request to instruction memory.
REQ-007 `ImemAddr` output, 32 bits: word-aligned request address.
REQ-008 `ImemGnt` input, 1 bit: memory accepts the request this cycle.
REQ-009 `ImemRvalid` input, 1 bit, and `ImemRdata` input, 32 bits: read response. Responses return in order, at least 1 cycle after grant.
REQ-010 `InstrValid`, `Instr` (32 bits), `InstrPC` (32 bits) and `InstrFault` (1 bit) outputs: instruction presented to decode.
REQ-011 `DecReady` input, 1 bit: decode consumes the instruction this cycle.

Function
REQ-012 The block SHALL track `Outstanding` (0..2), the number of granted requests not yet answered.
REQ-013 It SHALL hold a 2-entry in-order PC queue, with one entry per granted request.
REQ-014 It SHALL hold a 2-entry output FIFO of {PC, data, fault}.
REQ-015 Credit is Outstanding + FIFO count < 2. `ImemReq` = `PCValid` & credit & !`Flush`.
REQ-016 `ImemAddr` = {`PC`[31:2], 2'b00}.
REQ-017 `PCReady` = `ImemReq` & `ImemGnt`. This path is combinational, with zero-cycle accept.
REQ-018 A grant SHALL push `PC` onto the PC queue and increment `Outstanding`. A grant and a non-discarded response in the same cycle leave `Outstanding` unchanged.
REQ-019 A non-discarded response SHALL pop the PC queue and push {popped PC, `ImemRdata`, 0} onto the output FIFO.
REQ-020 Latency: `ImemRvalid` in cycle N SHALL produce `InstrValid` = 1 in cycle N+1.
REQ-021 `InstrValid` = output FIFO not empty. The head entry is popped when `InstrValid` & `DecReady`.
REQ-022 The FIFO head SHALL stay stable while `InstrValid` & !`DecReady`.
REQ-023 The FIFO SHALL support a simultaneous push and pop when it holds 1 or 2 entries. Credit guarantees that a push never hits a full FIFO.
REQ-024 The block SHALL have two states, RUN and DRAIN, with a `DiscardCnt` register (0..2).
REQ-025 `Flush` in any state SHALL, in the same cycle:
- clear the output FIFO and the PC queue;
- force `ImemReq` = 0;
- set `DiscardCnt` = `Outstanding` minus any response arriving that cycle;
- move to DRAIN if that value is nonzero, otherwise to RUN.
REQ-026 In DRAIN, each `ImemRvalid` SHALL be dropped and decrement `DiscardCnt`. The block returns to RUN when `DiscardCnt` reaches 0.
REQ-027 In DRAIN, new requests are allowed when credit permits. Their responses follow the discarded ones and are kept.
REQ-028 `Outstanding` SHALL decrement on every response, whether kept or dropped.
REQ-029 A `Flush` in the same cycle as `DecReady` pop: the flush wins and no entry survives.

Reset
REQ-030 `Rst` = 1 at a rising `Clk` edge SHALL clear `Outstanding`, `DiscardCnt`, the PC queue and the output FIFO, and set the state to RUN.
REQ-031 While `Rst` is asserted, `ImemReq`, `PCReady`, `InstrValid` and `InstrFault` SHALL be 0, and `Instr` and `InstrPC` SHALL be 32'h0.
REQ-032 The block SHALL accept a reset asserted mid-transfer. Responses to requests issued before reset SHALL be ignored; the environment guarantees that memory is reset concurrently.

Configuration
REQ-033 The macro `IFETCH_MISALIGN_CHK_EN` SHALL control misaligned-address checking.
REQ-034 With `IFETCH_MISALIGN_CHK_EN` defined, `PCValid` with `PC`[1:0] != 0 SHALL NOT raise `ImemReq`.
- It is accepted (`PCReady` = 1) when the output FIFO has room and `Outstanding` = 0.
- It then pushes {`PC`, 32'h00000013, 1}.
- `InstrValid` and `InstrFault` are seen the next cycle.
REQ-035 Without `IFETCH_MISALIGN_CHK_EN`, `PC`[1:0] SHALL be ignored and `InstrFault` SHALL be constant 0.

Structure
REQ-036 Shared package `rv32i_pkg` SHALL hold:
- `NOP_INSTR` = 32'h00000013;
- `IF_DEPTH` = 2;
- the fetch-entry struct type {pc, instr, fault}.
REQ-037 The output FIFO SHALL be the sub-module `fetch_fifo` (2 entries, with push, pop and clear). The PC queue SHALL reuse `fetch_fifo`.

Verification
REQ-038 Stream test: `PCValid` = 1, `PC` = 0, 4, 8; `ImemGnt` = 1 always; response 2 cycles after grant with data A, B, C; `DecReady` = 1. Decode SHALL see (0,A), (4,B), (8,C), each 1 cycle after its `ImemRvalid`.
REQ-039 Backpressure test: `DecReady` = 0 with 2 entries queued. `ImemReq` SHALL be 0 and `PCReady` SHALL be 0. Raising `DecReady` for 1 cycle SHALL restore `ImemReq` the next cycle.
REQ-040 Flush-drain test: 2 outstanding requests; `Flush` asserted; then the PC stage presents 0x100; responses X, Y, Z arrive. X and Y SHALL be dropped and decode SHALL see only (0x100, Z).
REQ-041 Reset-during-traffic test: assert `Rst` with 1 outstanding request and 1 queued entry. The next cycle SHALL show `InstrValid` = 0 and `ImemReq` = 0. After reset, the first fetch at 0 SHALL be returned correctly.
REQ-042 Misalign test, with `IFETCH_MISALIGN_CHK_EN` defined: `PC` = 0x6. No `ImemReq`; the next cycle SHALL show `InstrValid` = 1, `InstrFault` = 1, `Instr` = 0x00000013, `InstrPC` = 0x6.
